vclock_ranker: RTL and testbench

- Rank-assignment stage directly upstream of the two-port flow scheduler (PIFO).
- Implements VirtualClock tagging: each arriving packet gets rank = max(now, last_finish[flow]) + len × weight[flow].
- Accepts up to two arrivals per cycle and drives the scheduler's push_1/push_2 port groups one cycle later.
- Per-flow weights are programmable through a config write port.

---
 rtl/vclock_ranker.sv | 145 ++++++++++++++
 tb/tb_vclock_ranker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vclock_ranker.sv
// vclock_ranker: VirtualClock rank tagging ahead of a two-port PIFO scheduler.
// Each valid arrival gets rank = max(now, last_finish[flow]) + len * weight[flow].
// Up to two arrivals per cycle are handled. The result is registered and drives
// the scheduler push ports one cycle later.
module vclock_ranker #(
  parameter int FLOWS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arr_valid_1,
  input  logic [FLOWS-1:0] arr_flow_1,
  input  logic [15:0]      arr_len_1,
  input  logic [31:0]      arr_value_1,
  input  logic             arr_valid_2,
  input  logic [FLOWS-1:0] arr_flow_2,
  input  logic [15:0]      arr_len_2,
  input  logic [31:0]      arr_value_2,
  input  logic             cfg_we,
  input  logic [FLOWS-1:0] cfg_flow,
  input  logic [15:0]      cfg_weight,
  output logic             push_1,
  output logic [31:0]      push_rank_1,
  output logic [31:0]      push_value_1,
  output logic [FLOWS-1:0] push_flow_1,
  output logic             push_2,
  output logic [31:0]      push_rank_2,
  output logic [31:0]      push_value_2,
  output logic [FLOWS-1:0] push_flow_2,
  output logic [15:0]      drop_count
);

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [FLOWS-1:0] x);
    return (x != '0) && ((x & (x - FLOWS'(1))) == '0);
  endfunction

  logic [31:0] now_reg;
  logic [31:0] last_finish_reg [FLOWS];
  logic [15:0] weight_reg [FLOWS];

  logic        valid_1, valid_2, bad_1, bad_2, same_flow, cfg_ok;
  logic [31:0] lf_1, lf_2, base_2;
  logic [15:0] w_1, w_2;
  logic [31:0] cost_1, cost_2, start_1, start_2, rank_1, rank_2;
  logic [32:0] sum_1, sum_2;
  logic [16:0] drop_sum;
  logic [15:0] drop_next;

  // Per-flow lookups as one-hot AND-OR muxes. A malformed flow field is
  // never used, so its mux result does not matter.
  always_comb begin
    lf_1 = '0;
    lf_2 = '0;
    w_1  = '0;
    w_2  = '0;
    for (int i = 0; i < FLOWS; i++) begin
      lf_1 = lf_1 | ({32{arr_flow_1[i]}} & last_finish_reg[i]);
      lf_2 = lf_2 | ({32{arr_flow_2[i]}} & last_finish_reg[i]);
      w_1  = w_1  | ({16{arr_flow_1[i]}} & weight_reg[i]);
      w_2  = w_2  | ({16{arr_flow_2[i]}} & weight_reg[i]);
    end
  end

  // Tag computation: mux, multiply, max, saturating add. Arrival 1 is ordered
  // first, so a same-flow arrival 2 starts from rank_1.
  always_comb begin
    valid_1   = arr_valid_1 && is_onehot(arr_flow_1);
    valid_2   = arr_valid_2 && is_onehot(arr_flow_2);
    bad_1     = arr_valid_1 && !is_onehot(arr_flow_1);
    bad_2     = arr_valid_2 && !is_onehot(arr_flow_2);
    cfg_ok    = cfg_we && is_onehot(cfg_flow);
    same_flow = valid_1 && (arr_flow_1 == arr_flow_2);

    cost_1  = 32'(arr_len_1) * 32'(w_1);
    start_1 = (lf_1 > now_reg) ? lf_1 : now_reg;
    sum_1   = {1'b0, start_1} + {1'b0, cost_1};
    rank_1  = sum_1[32] ? 32'hFFFF_FFFF : sum_1[31:0];

    base_2  = same_flow ? rank_1 : lf_2;
    cost_2  = 32'(arr_len_2) * 32'(w_2);
    start_2 = (base_2 > now_reg) ? base_2 : now_reg;
    sum_2   = {1'b0, start_2} + {1'b0, cost_2};
    rank_2  = sum_2[32] ? 32'hFFFF_FFFF : sum_2[31:0];

    drop_sum  = {1'b0, drop_count} + 17'(bad_1) + 17'(bad_2);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Saturating time base.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      now_reg <= '0;
    end else if (now_reg != 32'hFFFF_FFFF) begin
      now_reg <= now_reg + 32'd1;
    end
  end

  // Per-flow state. Arrival 2 is later in order, so it wins last_finish on a
  // shared flow. Arrivals read the weight before a same-cycle write lands.
  generate
    for (genvar gi = 0; gi < FLOWS; gi++) begin : g_flow
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          last_finish_reg[gi] <= '0;
          weight_reg[gi]      <= 16'd1;
        end else begin
          if (valid_2 && arr_flow_2[gi]) begin
            last_finish_reg[gi] <= rank_2;
          end else if (valid_1 && arr_flow_1[gi]) begin
            last_finish_reg[gi] <= rank_1;
          end
          if (cfg_ok && cfg_flow[gi]) begin
            weight_reg[gi] <= cfg_weight;
          end
        end
      end
    end
  endgenerate

  // Output register toward the scheduler. Fields are zeroed when no push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_1       <= 1'b0;
      push_rank_1  <= '0;
      push_value_1 <= '0;
      push_flow_1  <= '0;
      push_2       <= 1'b0;
      push_rank_2  <= '0;
      push_value_2 <= '0;
      push_flow_2  <= '0;
      drop_count   <= '0;
    end else begin
      push_1       <= valid_1;
      push_rank_1  <= valid_1 ? rank_1 : '0;
      push_value_1 <= valid_1 ? arr_value_1 : '0;
      push_flow_1  <= valid_1 ? arr_flow_1 : '0;
      push_2       <= valid_2;
      push_rank_2  <= valid_2 ? rank_2 : '0;
      push_value_2 <= valid_2 ? arr_value_2 : '0;
      push_flow_2  <= valid_2 ? arr_flow_2 : '0;
      drop_count   <= drop_next;
    end
  end

endmodule

// File: tb/tb_vclock_ranker.sv
// Directed bench for vclock_ranker: table of per-cycle vectors plus
// hand-written reset sequences.
module tb_vclock_ranker;

  localparam int FLOWS = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             arr_valid_1, arr_valid_2, cfg_we;
  logic [FLOWS-1:0] arr_flow_1, arr_flow_2, cfg_flow;
  logic [15:0]      arr_len_1, arr_len_2, cfg_weight;
  logic [31:0]      arr_value_1, arr_value_2;
  logic             push_1, push_2;
  logic [31:0]      push_rank_1, push_rank_2, push_value_1, push_value_2;
  logic [FLOWS-1:0] push_flow_1, push_flow_2;
  logic [15:0]      drop_count;

  int total = 0;
  int bad   = 0;

  vclock_ranker #(.FLOWS(FLOWS)) dut (
    .clk(clk), .rst(rst),
    .arr_valid_1(arr_valid_1), .arr_flow_1(arr_flow_1), .arr_len_1(arr_len_1), .arr_value_1(arr_value_1),
    .arr_valid_2(arr_valid_2), .arr_flow_2(arr_flow_2), .arr_len_2(arr_len_2), .arr_value_2(arr_value_2),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_weight(cfg_weight),
    .push_1(push_1), .push_rank_1(push_rank_1), .push_value_1(push_value_1), .push_flow_1(push_flow_1),
    .push_2(push_2), .push_rank_2(push_rank_2), .push_value_2(push_value_2), .push_flow_2(push_flow_2),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v1;
    logic [FLOWS-1:0] f1;
    logic [15:0]      l1;
    logic             v2;
    logic [FLOWS-1:0] f2;
    logic [15:0]      l2;
    logic             we;
    logic [FLOWS-1:0] cf;
    logic [15:0]      cw;
    logic             e_p1;
    logic [31:0]      e_r1;
    logic             e_p2;
    logic [31:0]      e_r2;
    logic [15:0]      e_drop;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v1, input logic [FLOWS-1:0] f1, input logic [15:0] l1,
    input logic v2, input logic [FLOWS-1:0] f2, input logic [15:0] l2,
    input logic we, input logic [FLOWS-1:0] cf, input logic [15:0] cw,
    input logic e_p1, input logic [31:0] e_r1,
    input logic e_p2, input logic [31:0] e_r2, input logic [15:0] e_drop);
    vec_t v;
    v.v1 = v1; v.f1 = f1; v.l1 = l1;
    v.v2 = v2; v.f2 = f2; v.l2 = l2;
    v.we = we; v.cf = cf; v.cw = cw;
    v.e_p1 = e_p1; v.e_r1 = e_r1; v.e_p2 = e_p2; v.e_r2 = e_r2; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    arr_valid_1 = 0; arr_flow_1 = '0; arr_len_1 = '0; arr_value_1 = '0;
    arr_valid_2 = 0; arr_flow_2 = '0; arr_len_2 = '0; arr_value_2 = '0;
    cfg_we = 0; cfg_flow = '0; cfg_weight = '0;
  endtask

  initial begin
    // Table: one vector per cycle, starting at now = 5. Columns:
    // v1 f1 l1 | v2 f2 l2 | we cf cw | exp push1 rank1 push2 rank2 drop
    vecs[0]  = mk(1, 10'b1, 10,     0, 10'b0, 0,       0, 10'b0, 0,       1, 15,           0, 0,            0); // now 5
    vecs[1]  = mk(1, 10'b1, 4,      0, 10'b0, 0,       0, 10'b0, 0,       1, 19,           0, 0,            0); // now 6: max(6,15)+4
    vecs[2]  = mk(0, 10'b0, 0,      0, 10'b0, 0,       1, 10'b100, 3,     0, 0,            0, 0,            0); // weight[2]=3
    vecs[3]  = mk(1, 10'b100, 2,    1, 10'b100, 5,     0, 10'b0, 0,       1, 14,           1, 29,           0); // now 8: 8+6, 14+15
    vecs[4]  = mk(0, 10'b0, 0,      1, 10'b10, 1,      0, 10'b0, 0,       0, 0,            1, 10,           0); // now 9: port 2 only
    vecs[5]  = mk(1, 10'b0, 7,      1, 10'b11, 7,      0, 10'b0, 0,       0, 0,            0, 0,            2); // two malformed
    vecs[6]  = mk(1, 10'b1000, 3,   1, 10'b100, 1,     0, 10'b0, 0,       1, 14,           1, 32,           2); // now 11: 11+3, 29+3
    vecs[7]  = mk(1, 10'b100, 0,    1, 10'b1, 2,       1, 10'b101, 7,     1, 32,           1, 21,           2); // now 12, bad cfg ignored
    vecs[8]  = mk(1, 10'b1, 1,      1, 10'b101, 1,     0, 10'b0, 0,       1, 22,           0, 0,            3); // now 13: 21+1 w still 1
    vecs[9]  = mk(1, 10'b1000, 5,   0, 10'b0, 0,       1, 10'b1000, 0,    1, 19,           0, 0,            3); // now 14: old weight 1
    vecs[10] = mk(1, 10'b1000, 5,   0, 10'b0, 0,       0, 10'b0, 0,       1, 19,           0, 0,            3); // now 15: weight 0
    vecs[11] = mk(0, 10'b0, 0,      0, 10'b0, 0,       1, 10'h200, 16'hFFFF, 0, 0,         0, 0,            3); // weight[9]=FFFF
    vecs[12] = mk(1, 10'h200, 16'hFFFF, 1, 10'h200, 16'hFFFF, 0, 10'b0, 0, 1, 32'hFFFE0012, 1, 32'hFFFFFFFF, 3); // now 17
    vecs[13] = mk(1, 10'h200, 0,    0, 10'b0, 0,       0, 10'b0, 0,       1, 32'hFFFFFFFF, 0, 0,            3); // stays saturated

    // Reset state
    idle_inputs();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_push_1", 32'(push_1), 0);
    check("reset_push_2", 32'(push_2), 0);
    check("reset_drop", 32'(drop_count), 0);
    @(negedge clk);
    rst = 1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_push_1", 32'(push_1), 0);
    check("idle_push_2", 32'(push_2), 0);
    check("idle_rank_1", push_rank_1, 0);
    check("idle_drop", 32'(drop_count), 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      arr_valid_1 = vecs[i].v1; arr_flow_1 = vecs[i].f1; arr_len_1 = vecs[i].l1;
      arr_value_1 = 32'hA000_0000 + 32'(i);
      arr_valid_2 = vecs[i].v2; arr_flow_2 = vecs[i].f2; arr_len_2 = vecs[i].l2;
      arr_value_2 = 32'hB000_0000 + 32'(i);
      cfg_we = vecs[i].we; cfg_flow = vecs[i].cf; cfg_weight = vecs[i].cw;
      @(posedge clk);
      #1;
      $display("vec %0d: p1=%0d r1=%0h p2=%0d r2=%0h drop=%0d", i, push_1, push_rank_1, push_2, push_rank_2, drop_count);
      check($sformatf("v%0d_push_1", i), 32'(push_1), 32'(vecs[i].e_p1));
      check($sformatf("v%0d_push_2", i), 32'(push_2), 32'(vecs[i].e_p2));
      check($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].e_drop));
      if (vecs[i].e_p1) begin
        check($sformatf("v%0d_rank_1", i), push_rank_1, vecs[i].e_r1);
        check($sformatf("v%0d_value_1", i), push_value_1, 32'hA000_0000 + 32'(i));
        check($sformatf("v%0d_flow_1", i), 32'(push_flow_1), 32'(vecs[i].f1));
      end
      if (vecs[i].e_p2) begin
        check($sformatf("v%0d_rank_2", i), push_rank_2, vecs[i].e_r2);
        check($sformatf("v%0d_value_2", i), push_value_2, 32'hB000_0000 + 32'(i));
        check($sformatf("v%0d_flow_2", i), 32'(push_flow_2), 32'(vecs[i].f2));
      end
    end

    // Mid-stream reset: an output in flight is discarded immediately.
    @(negedge clk);
    idle_inputs();
    arr_valid_1 = 1; arr_flow_1 = 10'b1; arr_len_1 = 1; arr_value_1 = 32'hC0DE_0001;
    @(posedge clk);
    #1;
    $display("pre-reset: p1=%0d r1=%0h", push_1, push_rank_1);
    check("midrst_push_before", 32'(push_1), 1);
    check("midrst_rank_before", push_rank_1, 23); // now 19: max(19,22)+1
    #2;
    rst = 0;
    #1;
    $display("in reset: p1=%0d drop=%0d", push_1, drop_count);
    check("midrst_push_async", 32'(push_1), 0);
    check("midrst_rank_async", push_rank_1, 0);
    check("midrst_drop_async", 32'(drop_count), 0);
    idle_inputs();
    @(negedge clk);
    // Release and present arrivals for edge 0 (now = 0): weight[2] is back to 1,
    // last_finish[9] is back to 0.
    rst = 1;
    arr_valid_1 = 1; arr_flow_1 = 10'b100; arr_len_1 = 5; arr_value_1 = 32'h1111_2222;
    arr_valid_2 = 1; arr_flow_2 = 10'h200; arr_len_2 = 2; arr_value_2 = 32'h3333_4444;
    @(posedge clk);
    #1;
    $display("post-reset: p1=%0d r1=%0h p2=%0d r2=%0h", push_1, push_rank_1, push_2, push_rank_2);
    check("postrst_push_1", 32'(push_1), 1);
    check("postrst_rank_1", push_rank_1, 5);
    check("postrst_push_2", 32'(push_2), 1);
    check("postrst_rank_2", push_rank_2, 2);
    check("postrst_value_2", push_value_2, 32'h3333_4444);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("postrst_idle_push_1", 32'(push_1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
